// File: rtl/rv_pkg.sv
// Shared constants for the EX operand stage: ALU op codes and forwarding selects.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package rv_pkg;

   localparam int REG_IDX_W = 5;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // 2'b11 is never produced; consumers treat it like FWD_REG.
   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   // MEM beats WB because it holds the younger result; x0 is never forwarded.
   function automatic fwd_sel_e fwd_select(
      input logic [REG_IDX_W-1:0] rs,
      input logic [REG_IDX_W-1:0] rd_m,
      input logic                 we_m,
      input logic [REG_IDX_W-1:0] rd_w,
      input logic                 we_w
   );
      if (we_m && (rd_m != '0) && (rd_m == rs))
         return FWD_MEM;
      else if (we_w && (rd_w != '0) && (rd_w == rs))
         return FWD_WB;
      else
         return FWD_REG;
   endfunction

endpackage

// File: rtl/fwd_unit.sv
// Forwarding select generation for both EX source operands.
// Latency: purely combinational, zero cycles.
// Backpressure: none; follows registered Rs indices and live M/W writeback info.
// Ports: Rs1E/Rs2E (EX sources), RdM/RegWriteM, RdW/RegWriteW -> ForwardAE/ForwardBE.
module fwd_unit
   import rv_pkg::*;
(
   input  logic [REG_IDX_W-1:0] Rs1E,
   input  logic [REG_IDX_W-1:0] Rs2E,
   input  logic [REG_IDX_W-1:0] RdM,
   input  logic                 RegWriteM,
   input  logic [REG_IDX_W-1:0] RdW,
   input  logic                 RegWriteW,
   output logic [1:0]           ForwardAE,
   output logic [1:0]           ForwardBE
);

   always_comb begin
      ForwardAE = fwd_select(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_select(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
   end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register plus operand forwarding muxes feeding the ALU.
// Latency: one cycle D->E; forwarding/muxing adds zero cycles.
// Backpressure: StallE holds the register, FlushE loads a bubble (flush wins).
// Ports: clk/reset (sync, active-high); StallE/FlushE; D-stage decode fields in;
//        M/W forwarding sources in; SrcAE/SrcBE/WriteDataE, E control fields
//        and ForwardAE/ForwardBE out.
module ex_operand_stage
   import rv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 StallE,
   input  logic                 FlushE,
   input  logic                 ValidD,
   input  logic [XLEN-1:0]      RD1D,
   input  logic [XLEN-1:0]      RD2D,
   input  logic [XLEN-1:0]      ImmExtD,
   input  logic [REG_IDX_W-1:0] Rs1D,
   input  logic [REG_IDX_W-1:0] Rs2D,
   input  logic [REG_IDX_W-1:0] RdD,
   input  logic [2:0]           ALUControlD,
   input  logic                 ALUSrcD,
   input  logic                 RegWriteD,
   input  logic [XLEN-1:0]      ALUResultM,
   input  logic [REG_IDX_W-1:0] RdM,
   input  logic                 RegWriteM,
   input  logic [XLEN-1:0]      ResultW,
   input  logic [REG_IDX_W-1:0] RdW,
   input  logic                 RegWriteW,
   output logic [XLEN-1:0]      SrcAE,
   output logic [XLEN-1:0]      SrcBE,
   output logic [2:0]           ALUControlE,
   output logic [XLEN-1:0]      WriteDataE,
   output logic [REG_IDX_W-1:0] RdE,
   output logic                 RegWriteE,
   output logic                 ValidE,
   output logic [1:0]           ForwardAE,
   output logic [1:0]           ForwardBE
);

   typedef struct packed {
      logic                 valid;
      logic                 reg_write;
      logic [REG_IDX_W-1:0] rd;
      logic [REG_IDX_W-1:0] rs1;
      logic [REG_IDX_W-1:0] rs2;
      logic [XLEN-1:0]      rd1;
      logic [XLEN-1:0]      rd2;
      logic [XLEN-1:0]      imm;
      logic [2:0]           alu_ctrl;
      logic                 alu_src;
   } id_ex_t;

   id_ex_t ex_d;
   id_ex_t ex_q;

   // All-zero is the bubble: invalid, no write, ALU op add.
   always_comb begin
      ex_d = ex_q;
      if (FlushE) begin
         ex_d = '0;
      end else if (!StallE) begin
         ex_d.valid     = ValidD;
         // An invalid slot must never write the register file.
         ex_d.reg_write = RegWriteD & ValidD;
         ex_d.rd        = RdD;
         ex_d.rs1       = Rs1D;
         ex_d.rs2       = Rs2D;
         ex_d.rd1       = RD1D;
         ex_d.rd2       = RD2D;
         ex_d.imm       = ImmExtD;
         ex_d.alu_ctrl  = ALUControlD;
         ex_d.alu_src   = ALUSrcD;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         ex_q <= '0;
      else
         ex_q <= ex_d;
   end

   fwd_unit u_fwd_unit (
      .Rs1E      (ex_q.rs1),
      .Rs2E      (ex_q.rs2),
      .RdM       (RdM),
      .RegWriteM (RegWriteM),
      .RdW       (RdW),
      .RegWriteW (RegWriteW),
      .ForwardAE (ForwardAE),
      .ForwardBE (ForwardBE)
   );

   always_comb begin
      case (ForwardAE)
         FWD_WB:  SrcAE = ResultW;
         FWD_MEM: SrcAE = ALUResultM;
         default: SrcAE = ex_q.rd1;
      endcase
      case (ForwardBE)
         FWD_WB:  WriteDataE = ResultW;
         FWD_MEM: WriteDataE = ALUResultM;
         default: WriteDataE = ex_q.rd2;
      endcase
      SrcBE = ex_q.alu_src ? ex_q.imm : WriteDataE;
   end

   always_comb begin
      ALUControlE = ex_q.alu_ctrl;
      RdE         = ex_q.rd;
      ValidE      = ex_q.valid;
      RegWriteE   = ex_q.reg_write & ex_q.valid;
   end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed scenarios then randomized traffic,
// each cycle compared against a behavioural model of the ID/EX stage.
module tb_ex_operand_stage;
   import rv_pkg::*;

   localparam int XLEN = 32;

   logic            clk;
   logic            reset, StallE, FlushE, ValidD;
   logic [XLEN-1:0] RD1D, RD2D, ImmExtD, ALUResultM, ResultW;
   logic [4:0]      Rs1D, Rs2D, RdD, RdM, RdW;
   logic [2:0]      ALUControlD;
   logic            ALUSrcD, RegWriteD, RegWriteM, RegWriteW;
   logic [XLEN-1:0] SrcAE, SrcBE, WriteDataE;
   logic [2:0]      ALUControlE;
   logic [4:0]      RdE;
   logic            RegWriteE, ValidE;
   logic [1:0]      ForwardAE, ForwardBE;

   int n_assert = 0;
   int n_fail   = 0;

   // Model of the instruction currently sitting in EX.
   logic            m_valid, m_rw, m_alusrc;
   logic [4:0]      m_rd, m_rs1, m_rs2;
   logic [XLEN-1:0] m_rd1, m_rd2, m_imm;
   logic [2:0]      m_alu;

   ex_operand_stage #(.XLEN(XLEN)) dut (
      .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
      .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
      .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD), .RegWriteD(RegWriteD),
      .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
      .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW),
      .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUControlE(ALUControlE),
      .WriteDataE(WriteDataE), .RdE(RdE), .RegWriteE(RegWriteE), .ValidE(ValidE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Value an operand register should read, given who last wrote it.
   function automatic logic [XLEN-1:0] operand(input logic [4:0] rs, input logic [XLEN-1:0] regval);
      if (rs == 5'd0)                    return regval;
      if (RegWriteM && RdM == rs)        return ALUResultM;
      if (RegWriteW && RdW == rs)        return ResultW;
      return regval;
   endfunction

   function automatic logic [1:0] source(input logic [4:0] rs);
      if (rs == 5'd0)                    return 2'b00;
      if (RegWriteM && RdM == rs)        return 2'b10;
      if (RegWriteW && RdW == rs)        return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_clear();
      m_valid = 0; m_rw = 0; m_alusrc = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
      m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_alu = 0;
   endtask

   task automatic check_all(input string tag);
      logic [XLEN-1:0] wd;
      wd = operand(m_rs2, m_rd2);
      chk({tag, ".SrcAE"},      SrcAE,       operand(m_rs1, m_rd1));
      chk({tag, ".WriteDataE"}, WriteDataE,  wd);
      chk({tag, ".SrcBE"},      SrcBE,       m_alusrc ? m_imm : wd);
      chk({tag, ".ForwardAE"},  {30'd0, ForwardAE}, {30'd0, source(m_rs1)});
      chk({tag, ".ForwardBE"},  {30'd0, ForwardBE}, {30'd0, source(m_rs2)});
      chk({tag, ".ALUControlE"},{29'd0, ALUControlE}, {29'd0, m_alu});
      chk({tag, ".RdE"},        {27'd0, RdE}, {27'd0, m_rd});
      chk({tag, ".ValidE"},     {31'd0, ValidE}, {31'd0, m_valid});
      chk({tag, ".RegWriteE"},  {31'd0, RegWriteE}, {31'd0, m_rw});
   endtask

   // One clock: model follows the edge using the inputs held across it.
   task automatic tick(input string tag);
      @(posedge clk);
      if (reset || FlushE) begin
         model_clear();
      end else if (!StallE) begin
         m_valid = ValidD; m_rw = ValidD && RegWriteD; m_alusrc = ALUSrcD;
         m_rd = RdD; m_rs1 = Rs1D; m_rs2 = Rs2D;
         m_rd1 = RD1D; m_rd2 = RD2D; m_imm = ImmExtD; m_alu = ALUControlD;
      end
      #1;
      check_all(tag);
   endtask

   task automatic quiet_mw();
      ALUResultM = 0; RdM = 0; RegWriteM = 0; ResultW = 0; RdW = 0; RegWriteW = 0;
   endtask

   task automatic set_d(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [XLEN-1:0] r1,
                        input logic [XLEN-1:0] r2, input logic [XLEN-1:0] imm,
                        input logic [2:0] op, input logic asrc, input logic rw);
      ValidD = v; Rs1D = rs1; Rs2D = rs2; RdD = rd; RD1D = r1; RD2D = r2;
      ImmExtD = imm; ALUControlD = op; ALUSrcD = asrc; RegWriteD = rw;
   endtask

   logic [2:0] ops [5];

   initial begin
      ops[0] = ALU_ADD; ops[1] = ALU_SUB; ops[2] = ALU_AND; ops[3] = ALU_OR; ops[4] = ALU_SLT;
      model_clear();
      reset = 1; StallE = 0; FlushE = 0;
      set_d(1, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, ALU_SUB, 1, 1);
      quiet_mw();
      tick("reset0");
      tick("reset1");
      chk("reset.ValidE0", {31'd0, ValidE}, 32'd0);
      chk("reset.SrcAE0", SrcAE, 32'd0);

      // Plain capture, no forwarding.
      reset = 0;
      set_d(1, 5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 32'd0, ALU_ADD, 0, 1);
      tick("basic");
      chk("basic.SrcAE5", SrcAE, 32'd5);
      chk("basic.SrcBE7", SrcBE, 32'd7);

      // MEM and WB both target rs1: MEM wins.
      set_d(1, 5'd3, 5'd5, 5'd6, 32'hA, 32'hB, 32'd0, ALU_OR, 0, 1);
      ALUResultM = 32'h100; RdM = 3; RegWriteM = 1;
      ResultW = 32'h200; RdW = 3; RegWriteW = 1;
      tick("mem_prio");
      chk("mem_prio.Fwd10", {30'd0, ForwardAE}, 32'd2);
      chk("mem_prio.Src100", SrcAE, 32'h100);

      // x0 is never forwarded.
      quiet_mw();
      set_d(1, 5'd1, 5'd0, 5'd6, 32'hA, 32'hBEEF, 32'd0, ALU_AND, 0, 1);
      ALUResultM = 32'hFF; RdM = 0; RegWriteM = 1;
      tick("x0");
      chk("x0.SrcBE", SrcBE, 32'hBEEF);

      // Immediate operand with WB forwarding onto the store data.
      quiet_mw();
      set_d(1, 5'd1, 5'd7, 5'd8, 32'h1, 32'h2, 32'hFFFF_FFFC, ALU_ADD, 1, 0);
      ResultW = 32'd9; RdW = 7; RegWriteW = 1;
      tick("imm");
      chk("imm.SrcBE", SrcBE, 32'hFFFF_FFFC);
      chk("imm.WD9", WriteDataE, 32'd9);

      // Stall two cycles with changing D inputs, then flush while stalled.
      quiet_mw();
      set_d(1, 5'd9, 5'd10, 5'd11, 32'h99, 32'hAA, 32'h5, ALU_SLT, 0, 1);
      tick("pre_stall");
      StallE = 1;
      set_d(1, 5'd12, 5'd13, 5'd14, 32'h1, 32'h2, 32'h3, ALU_SUB, 1, 0);
      tick("stall1");
      set_d(0, 5'd15, 5'd16, 5'd17, 32'h4, 32'h5, 32'h6, ALU_OR, 0, 1);
      tick("stall2");
      chk("stall.RdE", {27'd0, RdE}, 32'd11);
      FlushE = 1;
      tick("flush");
      chk("flush.ALUCtl", {29'd0, ALUControlE}, 32'd0);
      StallE = 0; FlushE = 0;

      // Invalid decode slot never writes.
      set_d(0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, ALU_ADD, 0, 1);
      tick("invalid");

      // Reset mid-flight, then resume.
      set_d(1, 5'd4, 5'd5, 5'd6, 32'h44, 32'h55, 32'h66, ALU_SUB, 0, 1);
      tick("pre_reset");
      reset = 1;
      set_d(1, 5'd7, 5'd8, 5'd9, 32'h77, 32'h88, 32'h99, ALU_AND, 1, 1);
      tick("midreset");
      chk("midreset.SrcBE", SrcBE, 32'd0);
      reset = 0;
      tick("resume");
      chk("resume.RdE", {27'd0, RdE}, 32'd9);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         reset  = ($urandom_range(0, 49) == 0);
         FlushE = ($urandom_range(0, 7) == 0);
         StallE = ($urandom_range(0, 4) == 0);
         set_d($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 31)), $urandom, $urandom, $urandom,
               ops[$urandom_range(0, 4)], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         ALUResultM = $urandom; RdM = 5'($urandom_range(0, 3)); RegWriteM = 1'($urandom_range(0, 1));
         ResultW    = $urandom; RdW = 5'($urandom_range(0, 3)); RegWriteW = 1'($urandom_range(0, 1));
         tick("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
